// File: rtl/locked_reg_pkg.sv
// Shared defaults and helpers for the lockable register bank.
// Optional violation counter is enabled by defining LOCKED_REG_VIOL_CNT_EN.
package locked_reg_pkg;
  localparam int                    DEF_NUM_REGS  = 8;
  localparam int                    DEF_DATA_W    = 16;
  localparam logic [DEF_DATA_W-1:0] DEF_RESET_VAL = '0;
  localparam int                    VIOL_CNT_W    = 8;

  function automatic logic [VIOL_CNT_W-1:0] sat_inc(input logic [VIOL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/lock_reg_cell.sv
// One data register with a sticky lock bit; an untrusted write is blocked when
// the lock is already set or is being set in the same cycle. Latency: 1 cycle.
module lock_reg_cell
  import locked_reg_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(DEF_RESET_VAL)
) (
  input  logic              Clk,
  input  logic              resetn,
  input  logic              i_wr_sel,
  input  logic              i_trusted,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_lock_sel,
  output logic [DATA_W-1:0] o_data,
  output logic              o_lock,
  output logic              o_blocked
);
  logic [DATA_W-1:0] r_data;
  logic              r_lock;
  logic              w_blocked;

  // A lock request in the same cycle wins over an untrusted write.
  assign w_blocked = i_wr_sel && !i_trusted && (r_lock || i_lock_sel);

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      r_data <= RESET_VAL;
      r_lock <= 1'b0;
    end else begin
      if (i_lock_sel) r_lock <= 1'b1;
      if (i_wr_sel && !w_blocked) r_data <= i_wr_data;
    end
  end

  assign o_data    = r_data;
  assign o_lock    = r_lock;
  assign o_blocked = w_blocked;
endmodule

// File: rtl/locked_reg_bank.sv
// Bank of lockable registers with write ack/error, registered read and an
// optional saturating violation counter (macro LOCKED_REG_VIOL_CNT_EN).
module locked_reg_bank
  import locked_reg_pkg::*;
#(
  parameter int                NUM_REGS  = DEF_NUM_REGS,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                ADDR_W    = 3,
  parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(DEF_RESET_VAL)
) (
  input  logic                  Clk,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  trusted,
  input  logic                  lock_req,
  input  logic [ADDR_W-1:0]     lock_addr,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic [NUM_REGS-1:0]   lock_status,
  output logic [VIOL_CNT_W-1:0] viol_cnt
);
  localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

  logic [NUM_REGS-1:0] w_wr_sel;
  logic [NUM_REGS-1:0] w_lock_sel;
  logic [NUM_REGS-1:0] w_blocked;
  logic [NUM_REGS-1:0] w_lock;
  logic [DATA_W-1:0]   w_data [NUM_REGS];
  logic                w_wr_addr_ok;
  logic                w_any_blocked;
  logic [DATA_W-1:0]   w_rd_mux;

  logic [DATA_W-1:0]   r_rd_data;
  logic                r_wr_ack;
  logic                r_wr_err;

  assign w_wr_addr_ok = ({1'b0, wr_addr} < NREGS);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
    assign w_wr_sel[g]   = wr_en && (wr_addr == ADDR_W'(g));
    assign w_lock_sel[g] = lock_req && (lock_addr == ADDR_W'(g));

    lock_reg_cell #(
      .DATA_W    (DATA_W),
      .RESET_VAL (RESET_VAL)
    ) u_cell (
      .Clk        (Clk),
      .resetn     (resetn),
      .i_wr_sel   (w_wr_sel[g]),
      .i_trusted  (trusted),
      .i_wr_data  (wr_data),
      .i_lock_sel (w_lock_sel[g]),
      .o_data     (w_data[g]),
      .o_lock     (w_lock[g]),
      .o_blocked  (w_blocked[g])
    );
  end

  assign w_any_blocked = |w_blocked;

  // Out-of-range read addresses fall through to zero.
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) w_rd_mux = w_data[i];
    end
  end

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_data <= '0;
      r_wr_ack  <= 1'b0;
      r_wr_err  <= 1'b0;
    end else begin
      r_rd_data <= w_rd_mux;
      r_wr_ack  <= wr_en;
      r_wr_err  <= wr_en && (!w_wr_addr_ok || w_any_blocked);
    end
  end

`ifdef LOCKED_REG_VIOL_CNT_EN
  logic [VIOL_CNT_W-1:0] r_viol_cnt;

  // Only lock-blocked untrusted writes count; bad addresses do not.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      r_viol_cnt <= '0;
    end else if (w_any_blocked) begin
      r_viol_cnt <= sat_inc(r_viol_cnt);
    end
  end

  assign viol_cnt = r_viol_cnt;
`else
  assign viol_cnt = '0;
`endif

  assign rd_data     = r_rd_data;
  assign wr_ack      = r_wr_ack;
  assign wr_err      = r_wr_err;
  assign lock_status = w_lock;
endmodule

// File: tb/tb_locked_reg_bank.sv
// Directed, table-driven bench for locked_reg_bank (8 regs, 4-bit address so
// out-of-range addresses are reachable); follows LOCKED_REG_VIOL_CNT_EN.
module tb_locked_reg_bank;
  localparam logic [15:0] RV = 16'h00C3;
`ifdef LOCKED_REG_VIOL_CNT_EN
  localparam bit VIOL_ON = 1'b1;
`else
  localparam bit VIOL_ON = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        resetn;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        trusted;
  logic        lock_req;
  logic [3:0]  lock_addr;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        wr_ack;
  logic        wr_err;
  logic [7:0]  lock_status;
  logic [7:0]  viol_cnt;

  int total = 0;
  int bad   = 0;

  locked_reg_bank #(
    .NUM_REGS  (8),
    .DATA_W    (16),
    .ADDR_W    (4),
    .RESET_VAL (RV)
  ) dut (
    .Clk         (Clk),
    .resetn      (resetn),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .trusted     (trusted),
    .lock_req    (lock_req),
    .lock_addr   (lock_addr),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wr_ack      (wr_ack),
    .wr_err      (wr_err),
    .lock_status (lock_status),
    .viol_cnt    (viol_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        trusted;
    logic        lock_req;
    logic [3:0]  lock_addr;
    logic [3:0]  rd_addr;
    logic        ack;
    logic        err;
    logic [15:0] rd;
    logic [7:0]  lock;
    logic [7:0]  viol;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = 4'd0; wr_data = 16'h0; trusted = 1'b0;
    lock_req = 1'b0; lock_addr = 4'd0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic read_chk(input int a, input logic [15:0] exp, input string name);
    idle();
    rd_addr = 4'(a);
    step();
    chk(name, 32'(rd_data), 32'(exp));
  endtask

  task automatic check_all_regs(input logic [15:0] exp [8], input string name);
    for (int i = 0; i < 8; i++) read_chk(i, exp[i], name);
  endtask

  logic [15:0] exp_regs [8];
  logic [15:0] rv_regs  [8];

  initial begin
    //        wr a     data      tr    lk    la     rd     ack   err   rd        lock   viol
    vecs[0]  = '{1'b1, 4'd2, 16'hA5A5, 1'b0, 1'b0, 4'd0,  4'd2, 1'b1, 1'b0, RV,       8'h00, 8'd0};
    vecs[1]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0,  4'd2, 1'b0, 1'b0, 16'hA5A5, 8'h00, 8'd0};
    vecs[2]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 4'd2,  4'd2, 1'b0, 1'b0, 16'hA5A5, 8'h04, 8'd0};
    vecs[3]  = '{1'b1, 4'd2, 16'h1234, 1'b0, 1'b0, 4'd0,  4'd2, 1'b1, 1'b1, 16'hA5A5, 8'h04, 8'd1};
    vecs[4]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0,  4'd2, 1'b0, 1'b0, 16'hA5A5, 8'h04, 8'd1};
    vecs[5]  = '{1'b1, 4'd2, 16'h1234, 1'b1, 1'b0, 4'd0,  4'd2, 1'b1, 1'b0, 16'hA5A5, 8'h04, 8'd1};
    vecs[6]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0,  4'd2, 1'b0, 1'b0, 16'h1234, 8'h04, 8'd1};
    vecs[7]  = '{1'b1, 4'd5, 16'hBEEF, 1'b0, 1'b1, 4'd5,  4'd5, 1'b1, 1'b1, RV,       8'h24, 8'd2};
    vecs[8]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0,  4'd5, 1'b0, 1'b0, RV,       8'h24, 8'd2};
    vecs[9]  = '{1'b1, 4'd9, 16'hFFFF, 1'b0, 1'b0, 4'd0,  4'd9, 1'b1, 1'b1, 16'h0000, 8'h24, 8'd2};
    vecs[10] = '{1'b1, 4'd7, 16'h0707, 1'b0, 1'b1, 4'd12, 4'd7, 1'b1, 1'b0, RV,       8'h24, 8'd2};
    vecs[11] = '{1'b1, 4'd3, 16'h0303, 1'b0, 1'b0, 4'd0,  4'd7, 1'b1, 1'b0, 16'h0707, 8'h24, 8'd2};
    vecs[12] = '{1'b1, 4'd5, 16'h1111, 1'b1, 1'b0, 4'd0,  4'd3, 1'b1, 1'b0, 16'h0303, 8'h24, 8'd2};
    vecs[13] = '{1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0,  4'd5, 1'b0, 1'b0, 16'h1111, 8'h24, 8'd2};

    exp_regs = '{RV, RV, 16'h1234, 16'h0303, RV, 16'h1111, RV, 16'h0707};
    rv_regs  = '{RV, RV, RV, RV, RV, RV, RV, RV};

    // Reset state
    idle();
    rd_addr = 4'd0;
    resetn  = 1'b0;
    step();
    step();
    chk("rst_ack",  32'(wr_ack),      32'd0);
    chk("rst_err",  32'(wr_err),      32'd0);
    chk("rst_rd",   32'(rd_data),     32'd0);
    chk("rst_lock", 32'(lock_status), 32'd0);
    chk("rst_viol", 32'(viol_cnt),    32'd0);
    resetn = 1'b1;
    step();

    // Table of single-cycle operations
    for (int i = 0; i < 14; i++) begin
      wr_en     = vecs[i].wr_en;
      wr_addr   = vecs[i].wr_addr;
      wr_data   = vecs[i].wr_data;
      trusted   = vecs[i].trusted;
      lock_req  = vecs[i].lock_req;
      lock_addr = vecs[i].lock_addr;
      rd_addr   = vecs[i].rd_addr;
      step();
      chk($sformatf("v%0d_ack", i),  32'(wr_ack),      32'(vecs[i].ack));
      chk($sformatf("v%0d_err", i),  32'(wr_err),      32'(vecs[i].err));
      chk($sformatf("v%0d_rd", i),   32'(rd_data),     32'(vecs[i].rd));
      chk($sformatf("v%0d_lock", i), 32'(lock_status), 32'(vecs[i].lock));
      chk($sformatf("v%0d_viol", i), 32'(viol_cnt),    VIOL_ON ? 32'(vecs[i].viol) : 32'd0);
    end
    idle();
    step();
    chk("ack_drop", 32'(wr_ack), 32'd0);
    check_all_regs(exp_regs, "regs_after_table");
    read_chk(9, 16'h0000, "rd_oob9");

    // 300 back-to-back blocked untrusted writes to locked reg 2
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'hDEAD; trusted = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 0 || i == 299) begin
        chk("sat_ack", 32'(wr_ack), 32'd1);
        chk("sat_err", 32'(wr_err), 32'd1);
      end
    end
    idle();
    step();
    chk("viol_sat", 32'(viol_cnt), VIOL_ON ? 32'd255 : 32'd0);
    read_chk(2, 16'h1234, "reg2_after_sat");

    // Reset asserted with a write in flight and wr_data=FFFF held
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 16'hFFFF; trusted = 1'b1;
    lock_req = 1'b1; lock_addr = 4'd1;
    #2 resetn = 1'b0;
    #1;
    chk("rstf_ack",  32'(wr_ack),      32'd0);
    chk("rstf_lock", 32'(lock_status), 32'd0);
    step();
    step();
    chk("rstf_rd",   32'(rd_data),     32'd0);
    chk("rstf_viol", 32'(viol_cnt),    32'd0);
    idle();
    resetn = 1'b1;
    step();
    chk("rstf_no_ack", 32'(wr_ack), 32'd0);
    chk("rstf_no_err", 32'(wr_err), 32'd0);
    check_all_regs(rv_regs, "regs_after_reset");
    chk("lock_after_reset", 32'(lock_status), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/locked_reg_bank.md
LOCKED_REG_BANK -- requirements
Module: locked_reg_bank

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, meaning the number of lockable registers (2..64).
REQ-002 SHALL have parameter DATA_W, default 16, meaning the register width in bits.
REQ-003 SHALL have parameter ADDR_W, default 3, meaning the address width; it SHALL be at least clog2(NUM_REGS).
REQ-004 SHALL have parameter RESET_VAL, default 0, meaning the reset value of every register (DATA_W bits).
REQ-005 SHALL have port Clk, input, 1 bit: the single clock, rising-edge.
REQ-006 SHALL have port resetn, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port wr_en, input, 1 bit: write request this cycle.
REQ-008 SHALL have port wr_addr, input, ADDR_W bits: the write target index.
REQ-009 SHALL have port wr_data, input, DATA_W bits: the write data.
REQ-010 SHALL have port trusted, input, 1 bit: qualifies the current write as trusted.
REQ-011 SHALL have port lock_req, input, 1 bit: set the lock of register lock_addr.
REQ-012 SHALL have port lock_addr, input, ADDR_W bits: the lock target index.
REQ-013 SHALL have port rd_addr, input, ADDR_W bits: the read index.
REQ-014 SHALL have port rd_data, output, DATA_W bits: registered read data.
REQ-015 SHALL have port wr_ack, output, 1 bit: pulses 1 cycle after every wr_en.
REQ-016 SHALL have port wr_err, output, 1 bit: valid with wr_ack; 1 means the write was dropped.
REQ-017 SHALL have port lock_status, output, NUM_REGS bits: the per-register lock bits.
REQ-018 SHALL have port viol_cnt, output, 8 bits: count of blocked untrusted writes.

Function
REQ-019 SHALL make each lock bit sticky: set by lock_req at a valid lock_addr, cleared only by reset; no input, trusted or otherwise, clears it.
REQ-020 SHALL commit a write (register <= wr_data at the edge) when wr_en=1, wr_addr<NUM_REGS, and (lock bit=0 or trusted=1).
REQ-021 SHALL block an untrusted write when lock_req targets the same address in the same cycle: the lock wins, the register is unchanged, and wr_err=1.
REQ-022 SHALL drop a write with wr_addr>=NUM_REGS (no register changes) and report wr_err=1; this is not counted as a violation.
REQ-023 SHALL ignore lock_req with lock_addr>=NUM_REGS.
REQ-024 SHALL assert wr_ack and wr_err exactly one cycle after wr_en, for one cycle each; back-to-back wr_en yields back-to-back acks.
REQ-025 SHALL set rd_data from the register at rd_addr with 1-cycle latency; it reflects the pre-edge value on same-cycle write/read to one address (no bypass), and is 0 for rd_addr>=NUM_REGS.
REQ-026 SHALL increment viol_cnt by 1 for each write blocked by a lock with trusted=0, saturating at 255.
REQ-027 SHALL keep all registers holding their value when wr_en=0.

Reset
REQ-028 SHALL, while resetn=0, force every register to RESET_VAL and never load from wr_data or any input.
REQ-029 SHALL, while resetn=0, force lock_status=0, rd_data=0, wr_ack=0, wr_err=0 and viol_cnt=0.
REQ-030 SHALL discard a write in flight when reset asserts, with no wr_ack after release.

Configuration
REQ-031 SHALL, with macro LOCKED_REG_VIOL_CNT_EN defined, implement viol_cnt per REQ-026.
REQ-032 SHALL, with LOCKED_REG_VIOL_CNT_EN undefined, tie viol_cnt to 0 with no counter flops; wr_err behaviour is unchanged.

Structure
REQ-033 SHALL hold the default NUM_REGS, DATA_W, RESET_VAL and the viol_cnt width constant in package locked_reg_pkg.
REQ-034 SHALL implement each register plus its lock bit as sub-module lock_reg_cell, instantiated NUM_REGS times; address decode, ack, read mux and counter sit in the top.

Verification
REQ-035 SHALL cover: reset, then an untrusted write of 0xA5A5 to reg 2 -> next cycle wr_ack=1, wr_err=0; a read of reg 2 returns 0xA5A5.
REQ-036 SHALL cover: lock reg 2, then an untrusted write of 0x1234 -> wr_err=1, reg 2 stays 0xA5A5, viol_cnt=1; a trusted write of 0x1234 -> wr_err=0, reg 2 = 0x1234.
REQ-037 SHALL cover: same-cycle lock_req and untrusted wr_en to reg 5 -> wr_err=1, reg 5 = RESET_VAL, lock_status[5]=1.
REQ-038 SHALL cover: 300 blocked untrusted writes -> viol_cnt=255 (with the macro); viol_cnt=0 (without the macro).
REQ-039 SHALL cover: a write to addr 9 with NUM_REGS=8 -> wr_err=1, no register changes, viol_cnt unchanged; a read of addr 9 returns 0.
REQ-040 SHALL cover: resetn pulse with wr_data=0xFFFF held -> all registers = RESET_VAL and lock_status=0.
